// File: rtl/serial_frame_deserializer.sv
// Start-bit-triggered serial-to-parallel receiver for frames of N back-to-back words.
// Optional macro PARITY_CHECK_EN adds a trailing even-parity bit per word and a parity_err output.
module serial_frame_deserializer #(
  parameter int   WORD_SIZE = 8,
  parameter int   MAX_WORDS = 16,
  parameter int   LEN_W     = $clog2(MAX_WORDS) + 1,
  parameter logic START_BIT = 1'b0,
  parameter bit   MSB_FIRST = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_words,
  input  logic                 abort,
  input  logic                 data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 word_valid,
  output logic                 last_word,
  output logic [LEN_W-1:0]     word_count,
  output logic                 busy,
  output logic                 len_err
`ifdef PARITY_CHECK_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int               BIT_W    = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_SIZE - 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_SHIFT
`ifdef PARITY_CHECK_EN
    ,
    S_PARITY
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] shreg_q, shreg_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 word_valid_q, word_valid_d;
  logic                 last_word_q, last_word_d;
  logic [LEN_W-1:0]     word_count_q, word_count_d;
  logic                 len_err_q, len_err_d;
`ifdef PARITY_CHECK_EN
  logic                 parity_err_q, parity_err_d;
`endif

  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] word;
  logic [LEN_W-1:0]     count_inc;
  logic                 len_ok;
  logic                 complete;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = (shreg_q << 1) | {{(WORD_SIZE-1){1'b0}}, data_in};
    end else begin
      shifted = (shreg_q >> 1) | {data_in, {(WORD_SIZE-1){1'b0}}};
    end
  end

  assign count_inc = word_count_q + LEN_W'(1);
  assign len_ok    = (frame_words != '0) && (frame_words <= MAX_LEN);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    word_valid_d = 1'b0;
    last_word_d  = 1'b0;
    word_count_d = word_count_q;
    len_err_d    = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    complete     = 1'b0;
    word         = shifted;

    // abort outranks everything, including a word completing on this edge
    if (abort) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_d        = frame_words;
              word_count_d = '0;
              state_d      = S_HUNT;
            end else begin
              len_err_d = 1'b1;
            end
          end
        end
        S_HUNT: begin
          bit_cnt_d = '0;
          if (data_in == START_BIT) begin
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg_d = shifted;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d   = S_PARITY;
`else
            complete  = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        S_PARITY: begin
          complete     = 1'b1;
          word         = shreg_q;
          parity_err_d = ^{shreg_q, data_in};
        end
`endif
        default: state_d = S_IDLE;
      endcase

      if (complete) begin
        data_out_d   = word;
        word_valid_d = 1'b1;
        word_count_d = (word_count_q == len_q) ? word_count_q : count_inc;
        if (count_inc == len_q) begin
          last_word_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      word_valid_q <= 1'b0;
      last_word_q  <= 1'b0;
      word_count_q <= '0;
      len_err_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      word_valid_q <= word_valid_d;
      last_word_q  <= last_word_d;
      word_count_q <= word_count_d;
      len_err_q    <= len_err_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign word_valid = word_valid_q;
  assign last_word  = last_word_q;
  assign word_count = word_count_q;
  assign busy       = (state_q != S_IDLE);
  assign len_err    = len_err_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Randomized bench for serial_frame_deserializer; the model derives word timing from the
// frame layout (start bit, then BPW bits per word) and tracks the last delivered word.
module tb_serial_frame_deserializer;

  localparam int W    = 8;
  localparam int MAXW = 16;
  localparam int LW   = 5;
`ifdef PARITY_CHECK_EN
  localparam int BPW  = W + 1;
`else
  localparam int BPW  = W;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] frame_words;
  logic          abort;
  logic          data_in;
  logic [W-1:0]  data_out;
  logic          word_valid;
  logic          last_word;
  logic [LW-1:0] word_count;
  logic          busy;
  logic          len_err;
`ifdef PARITY_CHECK_EN
  logic          parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_data;
  logic [W-1:0] frame_data [MAXW];
  logic         frame_par_bad [MAXW];

  serial_frame_deserializer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .frame_words (frame_words),
    .abort       (abort),
    .data_in     (data_in),
    .data_out    (data_out),
    .word_valid  (word_valid),
    .last_word   (last_word),
    .word_count  (word_count),
    .busy        (busy),
    .len_err     (len_err)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Line bit b of word k: data bits LSB first, then (parity build) the even-parity bit.
  function automatic logic bit_of(input int k, input int b);
    if (b < W) return frame_data[k][b];
    return (^frame_data[k]) ^ frame_par_bad[k];
  endfunction

  task automatic clear_par();
    for (int i = 0; i < MAXW; i++) frame_par_bad[i] = 1'b0;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0 || last_word !== 1'b0 || len_err !== 1'b0 ||
        data_out !== exp_data) begin
      n_fail++;
      $display("FAIL %s: busy=%b valid=%b last=%b len_err=%b data=%h, required busy=0 valid=0 last=0 len_err=0 data=%h",
               name, busy, word_valid, last_word, len_err, data_out, exp_data);
    end
  endtask

  // Accept a frame of n words, hunt through pre_ones idle bits, then shift every word,
  // checking all outputs on every cycle. noise drives random start/frame_words while busy.
  task automatic run_frame(input int n, input int pre_ones, input bit noise);
    logic [LW-1:0] exp_cnt;
    bit fin;
    bit lastw;
    abort = 1'b0;
    data_in = 1'b1;
    start = 1'b1;
    frame_words = LW'(n);
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || word_count !== '0 || word_valid !== 1'b0 || len_err !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: busy=%b count=%0d valid=%b len_err=%b, required busy=1 count=0 valid=0 len_err=0",
               busy, word_count, word_valid, len_err);
    end
    for (int i = 0; i <= pre_ones; i++) begin
      data_in = (i == pre_ones) ? 1'b0 : 1'b1;
      start = noise ? 1'($urandom) : 1'b0;
      frame_words = LW'($urandom);
      tick();
      n_checks++;
      if (busy !== 1'b1 || word_valid !== 1'b0 || len_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hunt: busy=%b valid=%b len_err=%b, required busy=1 valid=0 len_err=0",
                 busy, word_valid, len_err);
      end
    end
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < BPW; b++) begin
        data_in = bit_of(k, b);
        start = noise ? 1'($urandom) : 1'b0;
        frame_words = LW'($urandom);
        tick();
        fin = (b == BPW - 1);
        lastw = fin && (k == n - 1);
        if (fin) exp_data = frame_data[k];
        exp_cnt = fin ? LW'(k + 1) : LW'(k);
        n_checks++;
        if (word_valid !== fin || data_out !== exp_data || word_count !== exp_cnt ||
            last_word !== lastw || busy !== !lastw || len_err !== 1'b0) begin
          n_fail++;
          $display("FAIL shift w%0d b%0d: valid=%b data=%h count=%0d last=%b busy=%b len_err=%b, required valid=%b data=%h count=%0d last=%b busy=%b len_err=0",
                   k, b, word_valid, data_out, word_count, last_word, busy, len_err,
                   fin, exp_data, exp_cnt, lastw, !lastw);
        end
`ifdef PARITY_CHECK_EN
        n_checks++;
        if (parity_err !== (fin && frame_par_bad[k])) begin
          n_fail++;
          $display("FAIL parity w%0d b%0d: parity_err=%b, required %b",
                   k, b, parity_err, fin && frame_par_bad[k]);
        end
`endif
        if (fin) $display("word %0d: data=%h count=%0d last=%b", k, data_out, word_count, last_word);
      end
    end
    start = 1'b0;
    data_in = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    data_in = 1'b1;
    frame_words = '0;
    exp_data = '0;
    clear_par();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle("reset");
    n_checks++;
    if (word_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: count=%0d, required 0", word_count);
    end
  endtask

  task automatic test_single();
    clear_par();
    frame_data[0] = 8'hA5;
    run_frame(1, 2, 1'b0);
    tick();
    check_idle("single_after");
  endtask

  task automatic test_multi();
    clear_par();
    frame_data[0] = 8'h01;
    frame_data[1] = 8'h80;
    frame_data[2] = 8'hFF;
    run_frame(3, 0, 1'b0);
    tick();
    check_idle("multi_after");
  endtask

  task automatic test_len_err();
    logic [LW-1:0] bad_len [3];
    bad_len[0] = 5'd0;
    bad_len[1] = 5'd17;
    bad_len[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      frame_words = bad_len[i];
      tick();
      start = 1'b0;
      n_checks++;
      if (len_err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL len_err %0d: len_err=%b busy=%b, required len_err=1 busy=0",
                 bad_len[i], len_err, busy);
      end
      $display("len %0d rejected: len_err=%b busy=%b", bad_len[i], len_err, busy);
      tick();
      check_idle("len_err_clear");
    end
  endtask

  task automatic test_abort();
    clear_par();
    for (int i = 0; i < 3; i++) frame_data[i] = W'($urandom);
    start = 1'b1;
    frame_words = 5'd3;
    tick();
    start = 1'b0;
    data_in = 1'b0;
    tick();
    for (int b = 0; b < BPW; b++) begin
      data_in = bit_of(0, b);
      tick();
    end
    exp_data = frame_data[0];
    n_checks++;
    if (word_valid !== 1'b1 || data_out !== exp_data || word_count !== 5'd1) begin
      n_fail++;
      $display("FAIL abort_word1: valid=%b data=%h count=%0d, required valid=1 data=%h count=1",
               word_valid, data_out, word_count, exp_data);
    end
    for (int b = 0; b < 5; b++) begin
      data_in = bit_of(1, b);
      tick();
    end
    abort = 1'b1;
    data_in = bit_of(1, 5);
    tick();
    abort = 1'b0;
    $display("abort mid-word: busy=%b data=%h", busy, data_out);
    for (int i = 0; i < 12; i++) begin
      data_in = 1'($urandom);
      tick();
      check_idle("abort_after");
    end
    // abort on the very edge that would complete the last word
    frame_data[0] = W'($urandom);
    start = 1'b1;
    frame_words = 5'd1;
    tick();
    start = 1'b0;
    data_in = 1'b0;
    tick();
    for (int b = 0; b < BPW; b++) begin
      data_in = bit_of(0, b);
      abort = (b == BPW - 1);
      tick();
    end
    abort = 1'b0;
    check_idle("abort_priority");
    // start and abort together in IDLE: no frame
    start = 1'b1;
    abort = 1'b1;
    frame_words = 5'd2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort");
  endtask

  task automatic test_async_reset();
    clear_par();
    frame_data[0] = W'($urandom);
    frame_data[1] = W'($urandom);
    start = 1'b1;
    frame_words = 5'd2;
    tick();
    start = 1'b0;
    data_in = 1'b0;
    tick();
    for (int b = 0; b < BPW + 3; b++) begin
      data_in = (b < BPW) ? bit_of(0, b) : bit_of(1, b - BPW);
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    exp_data = '0;
    check_idle("async_reset");
    n_checks++;
    if (word_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset_count: count=%0d, required 0", word_count);
    end
    $display("reset mid-word: busy=%b data=%h count=%0d", busy, data_out, word_count);
    tick();
    reset = 1'b0;
    check_idle("reset_hold");
    for (int i = 0; i < 2; i++) frame_data[i] = W'($urandom);
    run_frame(2, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, MAXW);
      for (int i = 0; i < MAXW; i++) begin
        frame_data[i] = W'($urandom);
`ifdef PARITY_CHECK_EN
        frame_par_bad[i] = 1'($urandom);
`else
        frame_par_bad[i] = 1'b0;
`endif
      end
      run_frame(n, $urandom_range(0, 3), 1'b1);
    end
    clear_par();
    frame_data[0] = 8'h3C;
    run_frame(1, 0, 1'b0);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    clear_par();
    frame_data[0] = 8'hA5;
    frame_data[1] = 8'hA5;
    frame_par_bad[1] = 1'b1;
    run_frame(2, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_len_err();
    test_abort();
    test_async_reset();
    test_back_to_back();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
